psum_accum_buffer: RTL and testbench

//   Downstream of the PE control FSM: takes the delayed partial-sum stream (p_valid/last_chanel) from the PE array.

---
 rtl/cnn_acc_pkg.sv | 59 +++++
 rtl/psum_accum_buffer_if.sv | 28 ++
 rtl/ofm_sync_fifo.sv | 55 +++++
 rtl/psum_accum_buffer.sv | 159 +++++++++++++++
 tb/tb_psum_accum_buffer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_acc_pkg.sv
// Shared widths, FSM state encodings and arithmetic helpers for the
// partial-sum accumulation buffer.
// Optional feature macro: PSUM_ACC_RELU_EN (ReLU clamp in requantization).
package cnn_acc_pkg;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FIRST = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // Sign-extend a PE partial sum to accumulator width.
  function automatic logic [ACC_W-1:0] sext_psum(input logic [DATA_W-1:0] p);
    sext_psum = {{(ACC_W-DATA_W){p[DATA_W-1]}}, p};
  endfunction

  // Saturating signed add; result is {saturated_flag, value}.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W+1-DATA_W){b[DATA_W-1]}}, b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      if (s[ACC_W]) begin
        sat_add = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        sat_add = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      sat_add = {1'b0, s[ACC_W-1:0]};
    end
  endfunction

  // Arithmetic right shift followed by a clamp into the output pixel range.
  function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] sum,
                                               input logic [3:0] shift);
    logic signed [ACC_W-1:0] r;
    logic signed [ACC_W-1:0] lo;
    logic signed [ACC_W-1:0] hi;
    r = sum >>> shift;
`ifdef PSUM_ACC_RELU_EN
    lo = ACC_W'(0);
    hi = ACC_W'((2 ** OUT_W) - 1);
`else
    lo = ACC_W'(-(2 ** (OUT_W - 1)));
    hi = ACC_W'((2 ** (OUT_W - 1)) - 1);
`endif
    if (r < lo) begin
      requant = lo[OUT_W-1:0];
    end else if (r > hi) begin
      requant = hi[OUT_W-1:0];
    end else begin
      requant = r[OUT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/psum_accum_buffer_if.sv
// Control, partial-sum and OFM write-back signals of the accumulation buffer.
interface psum_accum_buffer_if
  import cnn_acc_pkg::*;
;
  logic              start_conv;
  logic              end_conv;
  logic [3:0]        cfg_shift;
  logic              p_valid;
  logic              last_chanel;
  logic [DATA_W-1:0] psum;
  logic              ofm_valid;
  logic              ofm_ready;
  logic [OUT_W-1:0]  ofm_data;
  logic              ofm_last;
  logic              overflow;
  logic              busy;
  logic              done;

  modport slave (
    input  start_conv, end_conv, cfg_shift, p_valid, last_chanel, psum, ofm_ready,
    output ofm_valid, ofm_data, ofm_last, overflow, busy, done
  );

  modport master (
    output start_conv, end_conv, cfg_shift, p_valid, last_chanel, psum, ofm_ready,
    input  ofm_valid, ofm_data, ofm_last, overflow, busy, done
  );
endinterface

// File: rtl/ofm_sync_fifo.sv
// Show-ahead synchronous FIFO: head entry is visible on o_data whenever o_valid.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module ofm_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign o_valid = (r_count != {(AW+1){1'b0}});
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_data  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop && o_valid;
  assign w_push  = i_push && (!o_full || w_pop);

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/psum_accum_buffer.sv
// Partial-sum accumulation buffer: accumulates one tile row across input
// channel passes, requantizes on the last-channel pass and queues pixels for
// OFM write-back. The PE array cannot stall, so a full FIFO drops pixels and
// raises the sticky overflow flag.
// Optional feature macro: PSUM_ACC_RELU_EN (ReLU clamp; otherwise signed clamp).
module psum_accum_buffer
  import cnn_acc_pkg::*;
#(
  parameter int TILE_LEN   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  psum_accum_buffer_if.slave bus
);
  localparam int              PW      = $clog2(TILE_LEN);
  localparam logic [PW-1:0]   PTR_END = PW'(TILE_LEN - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [PW-1:0]    r_ptr;
  logic [3:0]       r_shift;
  logic [ACC_W-1:0] r_acc [TILE_LEN];
  logic             r_stage_valid;
  logic [OUT_W-1:0] r_stage_data;
  logic             r_stage_last;
  logic             r_overflow;
  logic             r_done;

  logic             w_active;
  logic             w_beat;
  logic             w_ptr_end;
  logic             w_start_ok;
  logic             w_sat;
  logic [ACC_W:0]   w_add;
  logic [ACC_W-1:0] w_sum;
  logic             w_fifo_valid;
  logic             w_fifo_full;
  logic             w_pop;
  logic             w_drop;
  logic [OUT_W:0]   w_fifo_dout;

  assign w_active   = (r_state == S_FIRST) || (r_state == S_ACCUM);
  assign w_beat     = bus.p_valid && w_active;
  assign w_ptr_end  = (r_ptr == PTR_END);
  assign w_start_ok = (r_state == S_IDLE) && bus.start_conv;
  assign w_pop      = w_fifo_valid && bus.ofm_ready;
  assign w_drop     = r_stage_valid && w_fifo_full && !w_pop;

  // New accumulator value: plain load on the first pass, saturating add afterwards.
  always_comb begin
    w_add = sat_add(r_acc[r_ptr], bus.psum);
    if (r_state == S_FIRST) begin
      w_sum = sext_psum(bus.psum);
      w_sat = 1'b0;
    end else begin
      w_sum = w_add[ACC_W-1:0];
      w_sat = w_add[ACC_W];
    end
  end

  // Next-state logic; end_conv wins over the row-end pass transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start_conv) begin
          w_state_nxt = S_FIRST;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FIRST, S_ACCUM: begin
        if (bus.end_conv) begin
          w_state_nxt = S_DRAIN;
        end else if (w_beat && w_ptr_end) begin
          w_state_nxt = bus.last_chanel ? S_FIRST : S_ACCUM;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_DRAIN: begin
        if (!r_stage_valid && !w_fifo_valid) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control registers: FSM, tile pointer, latched shift, sticky overflow, done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= {PW{1'b0}};
      r_shift    <= 4'd0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == S_DRAIN) && (w_state_nxt == S_IDLE);
      if (w_start_ok) begin
        r_ptr      <= {PW{1'b0}};
        r_shift    <= bus.cfg_shift;
        r_overflow <= 1'b0;
      end else begin
        if (w_beat) begin
          r_ptr <= w_ptr_end ? {PW{1'b0}} : r_ptr + 1'b1;
        end
        r_overflow <= r_overflow | (w_beat & w_sat) | w_drop;
      end
    end
  end

  // Accumulator RAM, written on every processed beat; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_acc[r_ptr] <= w_sum;
    end
  end

  // Requantize stage register feeding the FIFO one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage_valid <= 1'b0;
      r_stage_data  <= {OUT_W{1'b0}};
      r_stage_last  <= 1'b0;
    end else begin
      r_stage_valid <= w_beat && bus.last_chanel;
      if (w_beat && bus.last_chanel) begin
        r_stage_data <= requant(w_sum, r_shift);
        r_stage_last <= w_ptr_end;
      end
    end
  end

  ofm_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OUT_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_stage_valid),
    .i_data  ({r_stage_last, r_stage_data}),
    .i_pop   (bus.ofm_ready),
    .o_data  (w_fifo_dout),
    .o_valid (w_fifo_valid),
    .o_full  (w_fifo_full)
  );

  assign bus.ofm_valid = w_fifo_valid;
  assign bus.ofm_data  = w_fifo_dout[OUT_W-1:0];
  assign bus.ofm_last  = w_fifo_dout[OUT_W];
  assign bus.overflow  = r_overflow;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
endmodule

// File: tb/tb_psum_accum_buffer.sv
// Directed scoreboard bench for psum_accum_buffer. Expected pixels are queued
// when last-channel beats are driven and compared as the FIFO hands them out.
module tb_psum_accum_buffer;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   rx_cnt = 0;
  int   rx_mark;
  logic [8:0] exp_q [$];
  logic [8:0] e;

  psum_accum_buffer_if bus ();

  psum_accum_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_px(input int sum, input int sh);
    int r;
    r = sum >>> sh;
`ifdef PSUM_ACC_RELU_EN
    if (r < 0) r = 0;
    else if (r > 255) r = 255;
`else
    if (r < -128) r = -128;
    else if (r > 127) r = 127;
`endif
    return r[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [3:0] sh);
    bus.start_conv = 1'b1;
    bus.cfg_shift  = sh;
    tick;
    bus.start_conv = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic pass(input int v, input bit lc, input int sum, input int sh);
    for (int i = 0; i < 16; i++) begin
      bus.p_valid     = 1'b1;
      bus.psum        = v[15:0];
      bus.last_chanel = lc;
      if (lc) exp_q.push_back({i == 15, exp_px(sum, sh)});
      tick;
    end
    bus.p_valid     = 1'b0;
    bus.last_chanel = 1'b0;
  endtask

  task automatic finish_conv;
    bit seen;
    seen = 1'b0;
    bus.end_conv = 1'b1;
    tick;
    bus.end_conv = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      tick;
      if (bus.done) seen = 1'b1;
    end
    chk("done_pulse", 32'(seen), 32'd1);
    chk("idle_after_done", 32'(bus.busy), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: compare every accepted pixel against the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.ofm_valid && bus.ofm_ready) begin
      rx_cnt++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_unexpected got=%0h exp=none", {bus.ofm_last, bus.ofm_data});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pixel", 32'({bus.ofm_last, bus.ofm_data}), 32'(e));
      end
    end
  end

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    bus.start_conv = 1'b0;
    bus.end_conv = 1'b0;
    bus.cfg_shift = 4'd0;
    bus.p_valid = 1'b0;
    bus.last_chanel = 1'b0;
    bus.psum = 16'd0;
    bus.ofm_ready = 1'b1;
    tick;
    tick;
    chk("rst_valid", 32'(bus.ofm_valid), 32'd0);
    chk("rst_data", 32'(bus.ofm_data), 32'd0);
    chk("rst_last", 32'(bus.ofm_last), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    tick;

    // p_valid while IDLE must not produce anything
    bus.p_valid = 1'b1; bus.last_chanel = 1'b1; bus.psum = 16'd7;
    tick; tick; tick;
    bus.p_valid = 1'b0; bus.last_chanel = 1'b0;
    chk("idle_ignore_valid", 32'(bus.ofm_valid), 32'd0);
    chk("idle_ignore_busy", 32'(bus.busy), 32'd0);

    // Test 1: single channel ramp, latency and row-last marker
    start(4'd0);
    rx_mark = rx_cnt;
    for (int i = 0; i < 16; i++) begin
      bus.p_valid = 1'b1;
      bus.psum = 16'(i);
      bus.last_chanel = 1'b1;
      exp_q.push_back({i == 15, exp_px(i, 0)});
      tick;
      if (i == 0) chk("lat_after_1_edge", 32'(bus.ofm_valid), 32'd0);
      if (i == 1) chk("lat_after_2_edges", 32'(bus.ofm_valid), 32'd1);
    end
    bus.p_valid = 1'b0; bus.last_chanel = 1'b0;
    finish_conv;
    chk("t1_count", 32'(rx_cnt - rx_mark), 32'd16);

    // Test 2: three passes, shift 1, with a start_conv while busy that must be ignored
    start(4'd1);
    rx_mark = rx_cnt;
    pass(10, 1'b0, 0, 1);
    bus.start_conv = 1'b1; bus.cfg_shift = 4'd0;
    tick;
    bus.start_conv = 1'b0;
    pass(10, 1'b0, 0, 1);
    pass(10, 1'b1, 30, 1);
    finish_conv;
    chk("t2_count", 32'(rx_cnt - rx_mark), 32'd16);

    // Test 3: negative sum clamps per build option
    start(4'd0);
    pass(-5, 1'b1, -5, 0);
    finish_conv;

    // Test 4: backpressure, FIFO holds 4, 12 dropped, sticky overflow
    start(4'd0);
    rx_mark = rx_cnt;
    bus.ofm_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.p_valid = 1'b1;
      bus.psum = 16'(100 + i);
      bus.last_chanel = 1'b1;
      if (i < 4) exp_q.push_back({1'b0, exp_px(100 + i, 0)});
      tick;
    end
    bus.p_valid = 1'b0; bus.last_chanel = 1'b0;
    tick; tick; tick;
    chk("t4_overflow", 32'(bus.overflow), 32'd1);
    chk("t4_valid_held", 32'(bus.ofm_valid), 32'd1);
    chk("t4_head_data", 32'(bus.ofm_data), 32'd100);
    bus.ofm_ready = 1'b1;
    finish_conv;
    chk("t4_count", 32'(rx_cnt - rx_mark), 32'd4);
    chk("t4_overflow_sticky", 32'(bus.overflow), 32'd1);
    start(4'd0);
    chk("t4_overflow_cleared", 32'(bus.overflow), 32'd0);
    finish_conv;

    // Test 5: large sums, shift 12, no saturation
    start(4'd12);
    pass(32767, 1'b0, 0, 12);
    pass(32767, 1'b1, 65534, 12);
    finish_conv;
    chk("t5_no_overflow", 32'(bus.overflow), 32'd0);

    // Async reset while in ACCUM with pixels waiting in the FIFO
    start(4'd12);
    pass(32767, 1'b0, 0, 12);
    bus.ofm_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.p_valid = 1'b1;
      bus.psum = 16'h7FFF;
      bus.last_chanel = 1'b1;
      exp_q.push_back({1'b0, exp_px(65534, 12)});
      tick;
    end
    bus.p_valid = 1'b0; bus.last_chanel = 1'b0;
    tick; tick;
    chk("pre_rst_valid", 32'(bus.ofm_valid), 32'd1);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.ofm_valid), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_data", 32'(bus.ofm_data), 32'd0);
    exp_q.delete();
    bus.ofm_ready = 1'b1;
    tick;
    rst_n = 1'b1;
    tick;
    chk("post_rst_idle", 32'(bus.busy), 32'd0);
    chk("sb_final_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
